// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the active-high hex glyph table and the all-off pattern.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Glyphs in {g,f,e,d,c,b,a} order, active-high, for hex 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to {g..a} segment decoder, always active-high;
// output polarity is handled by the parent.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with per-digit dp, live blank mask and
// a one-cycle anti-ghost gap per slot. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV        = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            sm_duan,
    output logic                  sm_dp,
    output logic [DIGITS-1:0]     sm_wei,
    output logic                  frame
);

    localparam int   PC_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL   = (ACTIVE_LOW != 0);

    logic [PC_W-1:0]     pc;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] data_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic [DIGITS-1:0]   lz_mask;
    logic                slot_end;
    logic                frame_end;

    assign slot_end  = (pc == PC_W'(DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= '0;
            idx <= '0;
        end else begin
            pc <= slot_end ? '0 : pc + PC_W'(1);
            if (slot_end) begin
                idx <= frame_end ? '0 : idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sh <= '0;
            dp_sh   <= '0;
        end else if (load) begin
            data_sh <= data;
            dp_sh   <= dp;
        end
    end

`ifdef SEG7_LZB_EN
    logic zero_run;

    // Walk down from the most significant digit; digit 0 is never blanked
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (data_sh[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic              cur_lz;
    logic              suppress;
    logic [6:0]        seg_dec;
    logic [6:0]        duan_nxt;
    logic              dp_nxt;
    logic [DIGITS-1:0] wei_nxt;

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = data_sh[4*i +: 4];
                cur_dp    = dp_sh[i];
                cur_blank = blank[i];
                cur_lz    = lz_mask[i];
            end
        end
    end

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (seg_dec)
    );

    always_comb begin
        suppress = cur_blank || cur_lz || slot_end;
        duan_nxt = suppress ? SEG_OFF : seg_dec;
        dp_nxt   = !suppress && cur_dp;
        wei_nxt  = suppress ? '0 : (DIGITS'(1) << idx);
    end

    // Output register: polarity applied here
    always_ff @(posedge clk) begin
        if (reset) begin
            sm_duan <= {7{POL}};
            sm_dp   <= POL;
            sm_wei  <= {DIGITS{POL}};
            frame   <= 1'b0;
        end else begin
            sm_duan <= duan_nxt ^ {7{POL}};
            sm_dp   <= dp_nxt ^ POL;
            sm_wei  <= wei_nxt ^ {DIGITS{POL}};
            frame   <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4, active-low)
// against a cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  sm_duan;
    logic        sm_dp;
    logic [3:0]  sm_wei;
    logic        frame;

    int tests = 0;
    int errors = 0;

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data    (data),
        .dp      (dp),
        .blank   (blank),
        .sm_duan (sm_duan),
        .sm_dp   (sm_dp),
        .sm_wei  (sm_wei),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: cycles elapsed since reset plus the captured word
    int          n = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;

    logic [6:0]  exp_duan;
    logic        exp_dp;
    logic [3:0]  exp_wei;
    logic        exp_frame;

    task automatic tick();
        int  digit;
        bit  gap;
        bit  lzb;
        bit  sup;
        if (reset) begin
            exp_duan  = 7'h7F;
            exp_dp    = 1'b1;
            exp_wei   = 4'hF;
            exp_frame = 1'b0;
            n         = 0;
            m_data    = '0;
            m_dp      = '0;
        end else begin
            digit = (n / DIV) % DIGITS;
            gap   = (n % DIV) == DIV - 1;
`ifdef SEG7_LZB_EN
            lzb   = (digit >= 1) && ((m_data >> (4 * digit)) == 16'h0);
`else
            lzb   = 1'b0;
`endif
            sup       = gap || blank[digit] || lzb;
            exp_wei   = sup ? 4'hF : ~(4'b0001 << digit);
            exp_duan  = sup ? 7'h7F : ~glyph[m_data[4*digit +: 4]];
            exp_dp    = sup ? 1'b1 : ~m_dp[digit];
            exp_frame = (n % FRAME) == FRAME - 1;
            n = n + 1;
            if (load) begin
                m_data = data;
                m_dp   = dp;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (sm_wei !== 4'hF || sm_duan !== 7'h7F || sm_dp !== 1'b1 || frame !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got wei=%b duan=%h dp=%b frame=%b, want 1111 7f 1 0",
                         sm_wei, sm_duan, sm_dp, frame);
            end
        end
        reset = 1'b0;
        tick();
        tests++;
        if (sm_wei !== 4'b1110 || sm_duan !== 7'h40 || sm_dp !== 1'b1) begin
            errors++;
            $display("FAIL first_after_reset: got wei=%b duan=%h dp=%b, want 1110 40 1",
                     sm_wei, sm_duan, sm_dp);
        end
    endtask

    task automatic run_checked(string name, int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            tests++;
            if (sm_wei !== exp_wei || sm_duan !== exp_duan || sm_dp !== exp_dp || frame !== exp_frame) begin
                errors++;
                $display("FAIL %s cyc%0d: got wei=%b duan=%h dp=%b frame=%b, want %b %h %b %b",
                         name, i, sm_wei, sm_duan, sm_dp, frame, exp_wei, exp_duan, exp_dp, exp_frame);
            end
        end
    endtask

    task automatic do_load(logic [15:0] d, logic [3:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_scan();
        int frames;
        do_load(16'h1234, 4'h0);
        run_checked("scan_1234", 2 * FRAME);
        frames = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame === 1'b1) frames++;
        end
        tests++;
        if (frames != 2) begin
            errors++;
            $display("FAIL frame_rate: got %0d pulses in 32 cycles, want 2", frames);
        end
    endtask

    task automatic test_lzb();
        do_load(16'h0005, 4'h0);
        run_checked("lzb_0005", FRAME);
        do_load(16'h0000, 4'h0);
        run_checked("lzb_0000", FRAME);
    endtask

    task automatic test_blank_dp();
        blank = 4'b0100;
        do_load(16'hABCD, 4'b0001);
        run_checked("blank_dp", FRAME + 3);
        for (int i = 0; i < 24; i++) begin
            blank = 4'($urandom_range(0, 15));
            run_checked("blank_live", 1);
        end
        blank = 4'b0000;
    endtask

    task automatic test_load_on_advance();
        logic [15:0] nd;
        int          budget;
        logic [3:0]  nxt;
        budget = 0;
        while ((n % DIV) != DIV - 1 && budget < 64) begin
            run_checked("adv_wait", 1);
            budget++;
        end
        tests++;
        if (budget >= 64) begin
            errors++;
            $display("FAIL adv_wait_timeout: got %0d cycles, want < 64", budget);
        end
        nxt = 4'(((n / DIV) + 1) % DIGITS);
        nd = 16'($urandom) | 16'h8888;
        data = nd;
        dp   = 4'hF;
        load = 1'b1;
        run_checked("adv_load_edge", 1);
        load = 1'b0;
        run_checked("adv_next", 1);
        tests++;
        if (sm_duan !== ~glyph[nd[4*nxt +: 4]] || sm_wei !== ~(4'b0001 << nxt) || sm_dp !== 1'b0) begin
            errors++;
            $display("FAIL adv_new_nibble: got duan=%h wei=%b dp=%b, want %h %b 0",
                     sm_duan, sm_wei, sm_dp, ~glyph[nd[4*nxt +: 4]], ~(4'b0001 << nxt));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            data  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
            dp    = 4'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            run_checked("random", 1);
        end
        load  = 1'b0;
        blank = 4'h0;
    endtask

    task automatic test_reset_mid();
        int budget;
        do_load(16'h7777, 4'hF);
        budget = 0;
        while ((n % FRAME) != 2 * DIV + 1 && budget < 64) begin
            run_checked("mid_wait", 1);
            budget++;
        end
        tests++;
        if (budget >= 64 || sm_wei !== 4'b1011) begin
            errors++;
            $display("FAIL mid_on_digit2: got wei=%b after %0d cycles, want 1011", sm_wei, budget);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (sm_wei !== 4'hF || sm_duan !== 7'h7F || sm_dp !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_off: got wei=%b duan=%h dp=%b frame=%b, want 1111 7f 1 0",
                     sm_wei, sm_duan, sm_dp, frame);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (sm_wei !== 4'b1110 || sm_duan !== 7'h40 || sm_dp !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: got wei=%b duan=%h dp=%b, want 1110 40 1",
                     sm_wei, sm_duan, sm_dp);
        end
        run_checked("mid_after", FRAME);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lzb();
        test_blank_dp();
        test_load_on_advance();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
